seq_mag_comp: RTL

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands one DIGIT-bit slice per clock, starting from the most significant slice. It stops early at the first slice that differs, and supports signed (two's-complement) as well as unsigned comparison. It sits in the cruise-control datapath between the speed registers and the control FSM, and replaces the fixed 8-bit combinational ripple comparator wherever operands are wider or timing is tight.

---
 rtl/seq_mag_comp.sv | 116 +++++++++++
 1 files changed

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: one DIGIT-bit slice per cycle, MSB slice first, early exit.
// Latency: 1..NDIG cycles after the accepting edge (NDIG when operands are equal).
// Backpressure: start is accepted only while busy=0; start while busy is dropped, not queued.
module seq_mag_comp #(
    parameter int WIDTH     = 16,
    parameter int DIGIT     = 4,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NDIG = WIDTH / DIGIT;
    // Slice index needs at least one bit even for a single-slice instance.
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPARE = 1'b1
    } state_t;

    state_t             state;
    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sgn_q;

    logic [DIGIT-1:0]   a_sl;
    logic [DIGIT-1:0]   b_sl;
    logic               top_sl;
    logic               last_sl;
    logic               sl_gt;
    logic               sl_lt;

    // Select slice k of both latched operands and order them; flipping the sign bit of the
    // top slice maps two's-complement ordering onto plain unsigned ordering.
    always_comb begin
        a_sl    = '0;
        b_sl    = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (k == KW'(i)) begin
                a_sl = a_q[i*DIGIT +: DIGIT];
                b_sl = b_q[i*DIGIT +: DIGIT];
            end
        end
        top_sl  = (k == KW'(NDIG - 1));
        last_sl = (k == '0);
        if (top_sl && sgn_q) begin
            a_sl[DIGIT-1] = ~a_sl[DIGIT-1];
            b_sl[DIGIT-1] = ~b_sl[DIGIT-1];
        end
        sl_gt   = (a_sl > b_sl);
        sl_lt   = (a_sl < b_sl);
    end

    // Control FSM with registered results; results only move on the edge that raises done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        sgn_q <= signed_mode & SIGNED_EN;
                        k     <= KW'(NDIG - 1);
                        busy  <= 1'b1;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (sl_gt || sl_lt) begin
                        // First differing slice decides the whole compare.
                        gt    <= sl_gt;
                        lt    <= sl_lt;
                        eq    <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (last_sl) begin
                        gt    <= 1'b0;
                        lt    <= 1'b0;
                        eq    <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
